// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and helpers for the sequential instruction controller
package ctrl_pkg;

    localparam int SEL_MAX  = 8;
    localparam int WORD_MAX = 64;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ALU  = 2'b01,
        OP_COPY = 2'b10,
        OP_COND = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_e;

    // Select fields are sized for the widest supported SEL_W; users keep the low bits.
    typedef struct packed {
        logic               regs_set;
        logic [SEL_MAX-1:0] savesel;
        logic [SEL_MAX-1:0] loadsel;
        logic [SEL_MAX-1:0] alu_opc;
        logic [SEL_MAX-1:0] cond_opc;
        logic               is_cond;
    } ctrl_word_t;

    function automatic logic is_halt_word(input logic [WORD_MAX-1:0] word, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < WORD_MAX; i++) begin
            if (i < width && !word[i]) begin
                all_ones = 1'b0;
            end
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction word to control word decoder
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 3,
    parameter int LOAD_DST = 0,
    parameter int ALU_DST  = 3
) (
    input  logic [DATA_W-1:0] instr,
    output ctrl_word_t        cw
);

    opcode_e          op;
    logic [SEL_W-1:0] arg0;
    logic [SEL_W-1:0] arg1;

    assign op   = opcode_e'(instr[DATA_W-1 -: 2]);
    assign arg0 = instr[SEL_W-1:0];
    assign arg1 = instr[2*SEL_W-1:SEL_W];

    always_comb begin
        cw = '0;
        case (op)
            OP_LOAD: begin
                cw.regs_set = 1'b1;
                cw.savesel  = SEL_MAX'(LOAD_DST);
            end
            OP_ALU: begin
                cw.regs_set = 1'b1;
                cw.savesel  = SEL_MAX'(ALU_DST);
                cw.alu_opc  = SEL_MAX'(arg0);
            end
            OP_COPY: begin
                cw.regs_set = 1'b1;
                cw.savesel  = SEL_MAX'(arg0);
                cw.loadsel  = SEL_MAX'(arg1);
            end
            OP_COND: begin
                cw.is_cond  = 1'b1;
                cw.cond_opc = SEL_MAX'(arg0);
            end
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - multi-cycle FETCH/EXEC instruction controller with halt and retire count
module seq_controller
    import ctrl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 3,
    parameter int LOAD_DST = 0,
    parameter int ALU_DST  = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] databus,
    input  logic              fetch_ack,
    input  logic              cond_true,
    output logic              fetch_req,
    output logic [1:0]        opcode,
    output logic [DATA_W-3:0] arg,
    output logic [SEL_W-1:0]  arg0,
    output logic [SEL_W-1:0]  arg1,
    output logic              regs_set,
    output logic [SEL_W-1:0]  regs_savesel,
    output logic [SEL_W-1:0]  regs_loadsel,
    output logic [SEL_W-1:0]  alu_opc,
    output logic [SEL_W-1:0]  cond_opc,
    output logic              pc_set,
    output logic              pc_inc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    if (DATA_W < 2 + 2*SEL_W) begin : g_bad_width
        $error("seq_controller: DATA_W must be at least 2 + 2*SEL_W");
    end
    if (SEL_W > SEL_MAX || DATA_W > WORD_MAX) begin : g_bad_range
        $error("seq_controller: SEL_W or DATA_W exceeds package limits");
    end

    state_e            state;
    logic [DATA_W-1:0] ir;
    ctrl_word_t        cw;
    logic              cw_unused;
    logic              halt_in;
    logic              halt_ir;
    logic              regs_set_q;
    logic              pc_inc_q;
    logic              cond_exec_q;
    logic              halted_q;

    ctrl_decode #(
        .DATA_W   (DATA_W),
        .SEL_W    (SEL_W),
        .LOAD_DST (LOAD_DST),
        .ALU_DST  (ALU_DST)
    ) u_decode (
        .instr (databus),
        .cw    (cw)
    );

    assign cw_unused = ^cw;
    assign halt_in   = is_halt_word(WORD_MAX'(databus), DATA_W);
    assign halt_ir   = is_halt_word(WORD_MAX'(ir), DATA_W);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FETCH;
            ir           <= '0;
            retired      <= '0;
            regs_savesel <= '0;
            regs_loadsel <= '0;
            alu_opc      <= '0;
            cond_opc     <= '0;
            regs_set_q   <= 1'b0;
            pc_inc_q     <= 1'b0;
            cond_exec_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch_ack) begin
                        ir           <= databus;
                        regs_savesel <= cw.savesel[SEL_W-1:0];
                        regs_loadsel <= cw.loadsel[SEL_W-1:0];
                        alu_opc      <= cw.alu_opc[SEL_W-1:0];
                        cond_opc     <= cw.cond_opc[SEL_W-1:0];
                        regs_set_q   <= cw.regs_set;
                        // The halt word is a Cond encoding, so only the cond path needs gating.
                        pc_inc_q     <= !cw.is_cond;
                        cond_exec_q  <= cw.is_cond && !halt_in;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    regs_set_q  <= 1'b0;
                    pc_inc_q    <= 1'b0;
                    cond_exec_q <= 1'b0;
                    if (halt_ir) begin
                        halted_q <= 1'b1;
                        state    <= HALT;
                    end else begin
                        retired <= retired + CNT_W'(1);
                        state   <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign fetch_req = (state == FETCH);
    assign opcode    = ir[DATA_W-1 -: 2];
    assign arg       = ir[DATA_W-3:0];
    assign arg0      = ir[SEL_W-1:0];
    assign arg1      = ir[2*SEL_W-1:SEL_W];
    assign regs_set  = regs_set_q;
    // Condition result is only meaningful once cond_opc is driven, so PC control follows it directly.
    assign pc_set    = cond_exec_q & cond_true;
    assign pc_inc    = pc_inc_q | (cond_exec_q & ~cond_true);
    assign halted    = halted_q;

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - self-checking bench for seq_controller
module tb_seq_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] databus;
    logic       fetch_ack;
    logic       cond_true;

    logic       fetch_req;
    logic [1:0] opcode;
    logic [5:0] arg;
    logic [2:0] arg0;
    logic [2:0] arg1;
    logic       regs_set;
    logic [2:0] regs_savesel;
    logic [2:0] regs_loadsel;
    logic [2:0] alu_opc;
    logic [2:0] cond_opc;
    logic       pc_set;
    logic       pc_inc;
    logic       halted;
    logic [15:0] retired;

    logic       w2_fetch_req;
    logic [1:0] w2_opcode_unused;
    logic [5:0] w2_arg_unused;
    logic [2:0] w2_arg0_unused;
    logic [2:0] w2_arg1_unused;
    logic       w2_regs_set;
    logic [2:0] w2_savesel_unused;
    logic [2:0] w2_loadsel_unused;
    logic [2:0] w2_alu_opc_unused;
    logic [2:0] w2_cond_opc_unused;
    logic       w2_pc_set;
    logic       w2_pc_inc;
    logic       w2_halted;
    logic [1:0] w2_retired;

    seq_controller dut (
        .clock        (clock),
        .reset        (reset),
        .databus      (databus),
        .fetch_ack    (fetch_ack),
        .cond_true    (cond_true),
        .fetch_req    (fetch_req),
        .opcode       (opcode),
        .arg          (arg),
        .arg0         (arg0),
        .arg1         (arg1),
        .regs_set     (regs_set),
        .regs_savesel (regs_savesel),
        .regs_loadsel (regs_loadsel),
        .alu_opc      (alu_opc),
        .cond_opc     (cond_opc),
        .pc_set       (pc_set),
        .pc_inc       (pc_inc),
        .halted       (halted),
        .retired      (retired)
    );

    seq_controller #(.CNT_W(2)) dut_w2 (
        .clock        (clock),
        .reset        (reset),
        .databus      (databus),
        .fetch_ack    (fetch_ack),
        .cond_true    (cond_true),
        .fetch_req    (w2_fetch_req),
        .opcode       (w2_opcode_unused),
        .arg          (w2_arg_unused),
        .arg0         (w2_arg0_unused),
        .arg1         (w2_arg1_unused),
        .regs_set     (w2_regs_set),
        .regs_savesel (w2_savesel_unused),
        .regs_loadsel (w2_loadsel_unused),
        .alu_opc      (w2_alu_opc_unused),
        .cond_opc     (w2_cond_opc_unused),
        .pc_set       (w2_pc_set),
        .pc_inc       (w2_pc_inc),
        .halted       (w2_halted),
        .retired      (w2_retired)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         model_retired = 0;
    logic [7:0] model_ir = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_common(input string tag, input bit e_fetch, input bit e_rs,
                                input bit e_ps, input bit e_pi, input bit e_halted);
        chk({tag, ".fetch_req"}, 32'(fetch_req), 32'(e_fetch));
        chk({tag, ".regs_set"},  32'(regs_set),  32'(e_rs));
        chk({tag, ".pc_set"},    32'(pc_set),    32'(e_ps));
        chk({tag, ".pc_inc"},    32'(pc_inc),    32'(e_pi));
        chk({tag, ".halted"},    32'(halted),    32'(e_halted));
        chk({tag, ".retired"},   32'(retired),   32'(model_retired % 65536));
        chk({tag, ".w2_fetch_req"}, 32'(w2_fetch_req), 32'(e_fetch));
        chk({tag, ".w2_regs_set"},  32'(w2_regs_set),  32'(e_rs));
        chk({tag, ".w2_pc_set"},    32'(w2_pc_set),    32'(e_ps));
        chk({tag, ".w2_pc_inc"},    32'(w2_pc_inc),    32'(e_pi));
        chk({tag, ".w2_halted"},    32'(w2_halted),    32'(e_halted));
        chk({tag, ".w2_retired"},   32'(w2_retired),   32'(model_retired % 4));
    endtask

    task automatic check_fields(input string tag);
        chk({tag, ".opcode"}, 32'(opcode), 32'(model_ir / 64));
        chk({tag, ".arg"},    32'(arg),    32'(model_ir % 64));
        chk({tag, ".arg0"},   32'(arg0),   32'(model_ir % 8));
        chk({tag, ".arg1"},   32'(arg1),   32'((model_ir / 8) % 8));
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        fetch_ack = 1'b0;
        tick();
        reset         = 1'b0;
        model_retired = 0;
        model_ir      = 8'h00;
        check_common(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_fields(tag);
        chk({tag, ".savesel"},  32'(regs_savesel), 32'd0);
        chk({tag, ".loadsel"},  32'(regs_loadsel), 32'd0);
        chk({tag, ".alu_opc"},  32'(alu_opc),      32'd0);
        chk({tag, ".cond_opc"}, 32'(cond_opc),     32'd0);
    endtask

    // Drives one instruction through fetch/exec starting from a FETCH cycle and checks each phase.
    task automatic run_instr(input logic [7:0] instr, input bit ctrue, input int stall);
        int op;
        int a0;
        int a1;
        bit halt;
        op   = int'(instr) / 64;
        a0   = int'(instr) % 8;
        a1   = (int'(instr) / 8) % 8;
        halt = (instr == 8'hFF);

        fetch_ack = 1'b0;
        for (int s = 0; s < stall; s++) begin
            databus   = 8'($urandom);
            cond_true = 1'($urandom);
            #1;
            check_common("stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check_fields("stall");
            tick();
        end

        databus   = instr;
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        databus   = 8'($urandom);
        cond_true = ctrue;
        #1;
        model_ir = instr;
        check_common("exec", 1'b0, !halt && op != 3, !halt && op == 3 && ctrue,
                     !halt && !(op == 3 && ctrue), 1'b0);
        check_fields("exec");
        case (op)
            0: begin
                chk("exec.load_savesel", 32'(regs_savesel), 32'd0);
                chk("exec.load_loadsel", 32'(regs_loadsel), 32'd0);
                chk("exec.load_alu",     32'(alu_opc),      32'd0);
                chk("exec.load_cond",    32'(cond_opc),     32'd0);
            end
            1: begin
                chk("exec.alu_savesel", 32'(regs_savesel), 32'd3);
                chk("exec.alu_opc",     32'(alu_opc),      32'(a0));
                chk("exec.alu_loadsel", 32'(regs_loadsel), 32'd0);
            end
            2: begin
                chk("exec.copy_savesel", 32'(regs_savesel), 32'(a0));
                chk("exec.copy_loadsel", 32'(regs_loadsel), 32'(a1));
            end
            default: begin
                chk("exec.cond_opc", 32'(cond_opc), 32'(a0));
            end
        endcase

        tick();
        if (!halt) begin
            model_retired++;
        end
        cond_true = 1'($urandom);
        #1;
        check_common("post", !halt, 1'b0, 1'b0, 1'b0, halt);
        check_fields("post");
    endtask

    initial begin
        reset     = 1'b1;
        fetch_ack = 1'b0;
        cond_true = 1'b0;
        databus   = 8'h00;
        tick();
        tick();
        do_reset("reset");

        run_instr(8'h00, 1'b0, 0);
        run_instr(8'h45, 1'b1, 0);
        run_instr(8'h9A, 1'b0, 1);
        run_instr(8'hC4, 1'b1, 0);
        run_instr(8'hC4, 1'b0, 0);

        run_instr(8'hFF, 1'b1, 5);
        for (int k = 0; k < 4; k++) begin
            fetch_ack = 1'b1;
            databus   = 8'h00;
            cond_true = 1'($urandom);
            tick();
            check_common("halt_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_fields("halt_hold");
        end
        do_reset("halt_exit");

        for (int n = 0; n < 40; n++) begin
            logic [7:0] instr;
            instr = 8'($urandom);
            if (instr == 8'hFF) begin
                instr = 8'hFE;
            end
            run_instr(instr, 1'($urandom), int'($urandom_range(0, 2)));
        end

        databus   = 8'h00;
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        #1;
        chk("mid.exec_regs_set", 32'(regs_set), 32'd1);
        do_reset("mid_exec_reset");

        run_instr(8'h3C, 1'b0, 1);
        run_instr(8'hFF, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
